ctrl_unit: RTL and testbench
============================

Name: ctrl_unit

Overview:
- Main instruction-decode/control block of the single-issue RV32I core.
- Takes opcode[6:2], func3 and func7 from the fetched instruction, plus the branch-comparator result.
- Drives immediate-format select, ALU operand muxes, ALU operation, register-file/data-memory enables, write-back select and next-PC select.
- Mostly combinational; a one-state-bit FSM adds a single wait cycle for loads.

Parameters:
- none

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  5  instruction bits [6:2]
- func3  in  3  instruction bits [14:12]
- func7  in  7  instruction bits [31:25]
- b  in  1  branch comparator result; 1 = condition selected by cmp_op is true
- imm_type  out  3  000 none, 001 U, 010 J, 011 S, 100 I, 101 B
- alu1_sel  out  1  ALU operand A: 0 = rs1, 1 = PC
- alu2_sel  out  1  ALU operand B: 0 = rs2, 1 = immediate
- alu_op  out  4  {sub/arith bit, func3}; 4'b1111 = pass operand B
- cmp_op  out  3  branch comparator function (func3)
- rf_we  out  1  register-file write enable
- wb_sel  out  2  write-back source: 00 ALU, 01 data memory, 10 PC+4
- dmem_we  out  1  data-memory write enable
- dmem_re  out  1  data-memory read enable
- mem_type  out  3  access size/sign (func3) for LOAD/STORE, else 000
- pc_sel  out  2  next PC: 00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared
- pc_we  out  1  PC update enable (0 = stall)
- illegal  out  1  unsupported opcode

Behaviour:
- Opcode decode:
  - LUI 01101: imm U, alu2 1, alu_op 1111, rf_we 1, wb 00.
  - AUIPC 00101: imm U, alu1 1, alu2 1, alu_op ADD, rf_we 1.
  - JAL 11011: imm J, alu1 1, alu2 1, rf_we 1, wb 10, pc_sel 01.
  - JALR 11001: imm I, alu1 0, alu2 1, ADD, rf_we 1, wb 10, pc_sel 10.
  - BRANCH 11000: imm B, alu1 0, alu2 0, cmp_op = func3, rf_we 0, pc_sel = b ? 01 : 00.
  - LOAD 00000: imm I, alu1 0, alu2 1, ADD, dmem_re 1, mem_type = func3, wb 01.
  - STORE 01000: imm S, alu1 0, alu2 1, ADD, dmem_we 1, mem_type = func3, rf_we 0.
  - OP 01100: imm none, alu1 0, alu2 0, alu_op = {func7[5], func3}, rf_we 1.
  - OP_IMM 00100: imm I, alu1 0, alu2 1, alu_op = {func3==101 ? func7[5] : 0, func3}, rf_we 1.
  - ADD = 4'b0000, SUB = 4'b1000, SRA/SRAI = 4'b1101.
- Defaults for unlisted fields: alu1 0, alu2 0, alu_op 0000, cmp_op 000, wb 00, mem_type 000, enables 0, pc_sel 00, pc_we 1.
- Any other opcode:
  - illegal = 1, rf_we = dmem_we = dmem_re = 0, pc_sel 00, pc_we 1 (skip instruction).
  - imm_type 000.
- Load FSM, state IDLE/WAIT:
  - IDLE with LOAD: rf_we 0, pc_we 0, next state WAIT.
  - WAIT: rf_we 1, pc_we 1, dmem_re 1; next state IDLE unconditionally, even if opcode changed.
  - All non-load instructions complete in one cycle in IDLE.
- Reset:
  - rst = 1 at a clk edge puts the FSM in IDLE.
  - While rst = 1: rf_we, dmem_we, dmem_re, pc_we forced 0; other outputs follow decode.
  - Reset during WAIT aborts the load with no register write.
- All decode outputs respond combinationally to opcode/func3/func7/b within the same cycle; only the FSM state is registered.

Test Plan:
- opcode LUI -> imm_type 001, alu2_sel 1, alu_op 1111, rf_we 1; then OP_IMM -> imm_type 100; then STORE func3 001 -> imm_type 011, dmem_we 1, rf_we 0, mem_type 001.
- opcode JAL -> alu1_sel 1, imm_type 010, pc_sel 01, wb_sel 10, rf_we 1; then LOAD -> alu1_sel 0, imm_type 100.
- LOAD func3 100 from IDLE -> cycle 1: pc_we 0, rf_we 0, dmem_re 1; cycle 2: rf_we 1, wb_sel 01, pc_we 1; cycle 3 returns to IDLE.
- BRANCH func3 000 with b=1 -> pc_sel 01, cmp_op 000; b=0 -> pc_sel 00; rf_we 0 in both.
- OP func3 000 func7 0100000 -> alu_op 1000; func7 0000000 -> 0000; OP_IMM func3 101 func7 0100000 -> alu_op 1101.
- rst=1 during load WAIT -> next cycle IDLE, rf_we/pc_we 0 while rst high; opcode 11111 -> illegal 1, all write enables 0.

Source files
------------

// File: rtl/ctrl_unit_if.sv
// Control bus between the instruction-decode block and the datapath.
// The datapath drives the instruction fields and branch result; the control
// unit returns the decoded control word and its load-wait state bit.
// No valid/ready handshake exists here: every field is a level that the
// control unit resolves combinationally in the same cycle it is presented.
interface ctrl_unit_if;
  logic [4:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       b;
  logic [2:0] imm_type;
  logic       alu1_sel;
  logic       alu2_sel;
  logic [3:0] alu_op;
  logic [2:0] cmp_op;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       dmem_we;
  logic       dmem_re;
  logic [2:0] mem_type;
  logic [1:0] pc_sel;
  logic       pc_we;
  logic       illegal;
  logic       load_wait;

  modport master (
    output opcode, func3, func7, b,
    input  imm_type, alu1_sel, alu2_sel, alu_op, cmp_op, rf_we, wb_sel,
           dmem_we, dmem_re, mem_type, pc_sel, pc_we, illegal, load_wait
  );

  modport slave (
    input  opcode, func3, func7, b,
    output imm_type, alu1_sel, alu2_sel, alu_op, cmp_op, rf_we, wb_sel,
           dmem_we, dmem_re, mem_type, pc_sel, pc_we, illegal, load_wait
  );
endinterface

// File: rtl/ctrl_unit.sv
// RV32I decode/control unit. Pure combinational decode of opcode/func3/
// func7/b, plus a one-bit FSM that holds the PC for one extra cycle on loads
// so the data memory result is written back in the second cycle.
module ctrl_unit (
  input logic       clk,
  input logic       rst,
  ctrl_unit_if.slave bus
);

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_U    = 3'b001;
  localparam logic [2:0] IMM_J    = 3'b010;
  localparam logic [2:0] IMM_S    = 3'b011;
  localparam logic [2:0] IMM_I    = 3'b100;
  localparam logic [2:0] IMM_B    = 3'b101;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t state, state_nxt;

  logic [2:0] imm_type;
  logic       alu1_sel;
  logic       alu2_sel;
  logic [3:0] alu_op;
  logic [2:0] cmp_op;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       dmem_we;
  logic       dmem_re;
  logic [2:0] mem_type;
  logic [1:0] pc_sel;
  logic       pc_we;
  logic       illegal;

  // Only func7[5] selects SUB/SRA; the remaining bits are deliberately ignored.
  logic unused_func7;
  assign unused_func7 = ^{bus.func7[6], bus.func7[4:0]};

  // State register: reset always returns to IDLE, aborting a pending load.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: a load in IDLE enters WAIT; WAIT always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.opcode == OPC_LOAD) state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: opcode decode, then load-wait overrides, then reset gating of enables.
  always_comb begin
    imm_type = IMM_NONE;
    alu1_sel = 1'b0;
    alu2_sel = 1'b0;
    alu_op   = ALU_ADD;
    cmp_op   = 3'b000;
    rf_we    = 1'b0;
    wb_sel   = 2'b00;
    dmem_we  = 1'b0;
    dmem_re  = 1'b0;
    mem_type = 3'b000;
    pc_sel   = 2'b00;
    pc_we    = 1'b1;
    illegal  = 1'b0;

    case (bus.opcode)
      OPC_LUI: begin
        imm_type = IMM_U;
        alu2_sel = 1'b1;
        alu_op   = ALU_PASS;
        rf_we    = 1'b1;
      end
      OPC_AUIPC: begin
        imm_type = IMM_U;
        alu1_sel = 1'b1;
        alu2_sel = 1'b1;
        rf_we    = 1'b1;
      end
      OPC_JAL: begin
        imm_type = IMM_J;
        alu1_sel = 1'b1;
        alu2_sel = 1'b1;
        rf_we    = 1'b1;
        wb_sel   = 2'b10;
        pc_sel   = 2'b01;
      end
      OPC_JALR: begin
        imm_type = IMM_I;
        alu2_sel = 1'b1;
        rf_we    = 1'b1;
        wb_sel   = 2'b10;
        pc_sel   = 2'b10;
      end
      OPC_BRANCH: begin
        imm_type = IMM_B;
        cmp_op   = bus.func3;
        pc_sel   = bus.b ? 2'b01 : 2'b00;
      end
      OPC_LOAD: begin
        // First cycle issues the read but stalls the PC and defers the write.
        imm_type = IMM_I;
        alu2_sel = 1'b1;
        dmem_re  = 1'b1;
        mem_type = bus.func3;
        wb_sel   = 2'b01;
        pc_we    = 1'b0;
      end
      OPC_STORE: begin
        imm_type = IMM_S;
        alu2_sel = 1'b1;
        dmem_we  = 1'b1;
        mem_type = bus.func3;
      end
      OPC_OP: begin
        alu_op = {bus.func7[5], bus.func3};
        rf_we  = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only the shift-right immediates carry an arithmetic flag in func7.
        imm_type = IMM_I;
        alu2_sel = 1'b1;
        alu_op   = {(bus.func3 == 3'b101) ? bus.func7[5] : 1'b0, bus.func3};
        rf_we    = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase

    // Second load cycle commits the write-back and releases the PC,
    // regardless of what instruction is now presented.
    if (state == WAIT) begin
      rf_we   = 1'b1;
      pc_we   = 1'b1;
      dmem_re = 1'b1;
    end

    if (rst) begin
      rf_we   = 1'b0;
      dmem_we = 1'b0;
      dmem_re = 1'b0;
      pc_we   = 1'b0;
    end
  end

  assign bus.imm_type  = imm_type;
  assign bus.alu1_sel  = alu1_sel;
  assign bus.alu2_sel  = alu2_sel;
  assign bus.alu_op    = alu_op;
  assign bus.cmp_op    = cmp_op;
  assign bus.rf_we     = rf_we;
  assign bus.wb_sel    = wb_sel;
  assign bus.dmem_we   = dmem_we;
  assign bus.dmem_re   = dmem_re;
  assign bus.mem_type  = mem_type;
  assign bus.pc_sel    = pc_sel;
  assign bus.pc_we     = pc_we;
  assign bus.illegal   = illegal;
  assign bus.load_wait = (state == WAIT);

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: each step drives one instruction for one
// cycle, queues the expected control word, and compares it mid-cycle.
module tb_ctrl_unit;

  localparam int W = 25;

  localparam logic [4:0] LUI    = 5'b01101;
  localparam logic [4:0] AUIPC  = 5'b00101;
  localparam logic [4:0] JAL    = 5'b11011;
  localparam logic [4:0] JALR   = 5'b11001;
  localparam logic [4:0] BRANCH = 5'b11000;
  localparam logic [4:0] LOAD   = 5'b00000;
  localparam logic [4:0] STORE  = 5'b01000;
  localparam logic [4:0] OP     = 5'b01100;
  localparam logic [4:0] OP_IMM = 5'b00100;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  ctrl_unit_if bus();

  ctrl_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word, fields in port order, load-wait state last.
  function automatic logic [W-1:0] ev(
    input logic [2:0] imm, input logic a1, input logic a2, input logic [3:0] op,
    input logic [2:0] cmp, input logic rfwe, input logic [1:0] wb,
    input logic dwe, input logic dre, input logic [2:0] mt,
    input logic [1:0] pcs, input logic pcwe, input logic ill, input logic st);
    return {imm, a1, a2, op, cmp, rfwe, wb, dwe, dre, mt, pcs, pcwe, ill, st};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.imm_type, bus.alu1_sel, bus.alu2_sel, bus.alu_op, bus.cmp_op,
            bus.rf_we, bus.wb_sel, bus.dmem_we, bus.dmem_re, bus.mem_type,
            bus.pc_sel, bus.pc_we, bus.illegal, bus.load_wait};
  endfunction

  // Driver: present one instruction for one cycle and queue its expectation.
  task automatic drive(input logic [4:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic bb, input logic r,
                       input logic [W-1:0] e, input string tag);
    @(posedge clk);
    #1;
    rst        = r;
    bus.opcode = opc;
    bus.func3  = f3;
    bus.func7  = f7;
    bus.b      = bb;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Scoreboard: pop the oldest expectation and compare at the falling edge.
  task automatic check();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    string        tag;
    @(negedge clk);
    got = observed();
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [4:0] opc, input logic [2:0] f3,
                      input logic [6:0] f7, input logic bb, input logic r,
                      input logic [W-1:0] e, input string tag);
    drive(opc, f3, f7, bb, r, e, tag);
    check();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    bus.opcode = LUI;
    bus.func3  = 3'b000;
    bus.func7  = 7'b0000000;
    bus.b      = 1'b0;
    repeat (2) @(posedge clk);

    // Reset: decode follows opcode, enables forced low, FSM idle
    step(LUI, 3'b000, 7'h00, 1'b0, 1'b1,
         ev(3'b001,0,1,4'b1111,3'b000,0,2'b00,0,0,3'b000,2'b00,0,0,0), "reset_lui");

    step(LUI, 3'b000, 7'h00, 1'b0, 1'b0,
         ev(3'b001,0,1,4'b1111,3'b000,1,2'b00,0,0,3'b000,2'b00,1,0,0), "lui");
    step(OP_IMM, 3'b000, 7'h00, 1'b0, 1'b0,
         ev(3'b100,0,1,4'b0000,3'b000,1,2'b00,0,0,3'b000,2'b00,1,0,0), "addi");
    step(STORE, 3'b001, 7'h00, 1'b0, 1'b0,
         ev(3'b011,0,1,4'b0000,3'b000,0,2'b00,1,0,3'b001,2'b00,1,0,0), "store_h");
    step(JAL, 3'b000, 7'h00, 1'b0, 1'b0,
         ev(3'b010,1,1,4'b0000,3'b000,1,2'b10,0,0,3'b000,2'b01,1,0,0), "jal");

    // Load: stall cycle, then write-back cycle, then back to IDLE
    step(LOAD, 3'b100, 7'h00, 1'b0, 1'b0,
         ev(3'b100,0,1,4'b0000,3'b000,0,2'b01,0,1,3'b100,2'b00,0,0,0), "load_c1");
    step(LOAD, 3'b100, 7'h00, 1'b0, 1'b0,
         ev(3'b100,0,1,4'b0000,3'b000,1,2'b01,0,1,3'b100,2'b00,1,0,1), "load_c2");
    step(BRANCH, 3'b000, 7'h00, 1'b1, 1'b0,
         ev(3'b101,0,0,4'b0000,3'b000,0,2'b00,0,0,3'b000,2'b01,1,0,0), "beq_taken");
    step(BRANCH, 3'b000, 7'h00, 1'b0, 1'b0,
         ev(3'b101,0,0,4'b0000,3'b000,0,2'b00,0,0,3'b000,2'b00,1,0,0), "beq_not_taken");
    step(BRANCH, 3'b101, 7'h00, 1'b1, 1'b0,
         ev(3'b101,0,0,4'b0000,3'b101,0,2'b00,0,0,3'b000,2'b01,1,0,0), "bge_taken");

    // ALU operation encoding
    step(OP, 3'b000, 7'b0100000, 1'b0, 1'b0,
         ev(3'b000,0,0,4'b1000,3'b000,1,2'b00,0,0,3'b000,2'b00,1,0,0), "sub");
    step(OP, 3'b000, 7'b0000000, 1'b0, 1'b0,
         ev(3'b000,0,0,4'b0000,3'b000,1,2'b00,0,0,3'b000,2'b00,1,0,0), "add");
    step(OP, 3'b101, 7'b0100000, 1'b0, 1'b0,
         ev(3'b000,0,0,4'b1101,3'b000,1,2'b00,0,0,3'b000,2'b00,1,0,0), "sra");
    step(OP_IMM, 3'b101, 7'b0100000, 1'b0, 1'b0,
         ev(3'b100,0,1,4'b1101,3'b000,1,2'b00,0,0,3'b000,2'b00,1,0,0), "srai");
    step(OP_IMM, 3'b000, 7'b0100000, 1'b0, 1'b0,
         ev(3'b100,0,1,4'b0000,3'b000,1,2'b00,0,0,3'b000,2'b00,1,0,0), "addi_f7_ignored");
    step(JALR, 3'b000, 7'h00, 1'b0, 1'b0,
         ev(3'b100,0,1,4'b0000,3'b000,1,2'b10,0,0,3'b000,2'b10,1,0,0), "jalr");
    step(AUIPC, 3'b000, 7'h00, 1'b0, 1'b0,
         ev(3'b001,1,1,4'b0000,3'b000,1,2'b00,0,0,3'b000,2'b00,1,0,0), "auipc");

    // Opcode change during WAIT still completes the load
    step(LOAD, 3'b000, 7'h00, 1'b0, 1'b0,
         ev(3'b100,0,1,4'b0000,3'b000,0,2'b01,0,1,3'b000,2'b00,0,0,0), "load_b_c1");
    step(OP, 3'b000, 7'h00, 1'b0, 1'b0,
         ev(3'b000,0,0,4'b0000,3'b000,1,2'b00,0,1,3'b000,2'b00,1,0,1), "wait_opcode_changed");
    step(LUI, 3'b000, 7'h00, 1'b0, 1'b0,
         ev(3'b001,0,1,4'b1111,3'b000,1,2'b00,0,0,3'b000,2'b00,1,0,0), "after_wait_idle");

    // Reset during WAIT aborts the load
    step(LOAD, 3'b010, 7'h00, 1'b0, 1'b0,
         ev(3'b100,0,1,4'b0000,3'b000,0,2'b01,0,1,3'b010,2'b00,0,0,0), "load_w_c1");
    step(LOAD, 3'b010, 7'h00, 1'b0, 1'b1,
         ev(3'b100,0,1,4'b0000,3'b000,0,2'b01,0,0,3'b010,2'b00,0,0,1), "rst_in_wait");
    step(LOAD, 3'b010, 7'h00, 1'b0, 1'b1,
         ev(3'b100,0,1,4'b0000,3'b000,0,2'b01,0,0,3'b010,2'b00,0,0,0), "rst_to_idle");

    // Unsupported opcodes
    step(5'b11111, 3'b111, 7'h7f, 1'b1, 1'b0,
         ev(3'b000,0,0,4'b0000,3'b000,0,2'b00,0,0,3'b000,2'b00,1,1,0), "illegal_11111");
    step(5'b00011, 3'b000, 7'h00, 1'b0, 1'b0,
         ev(3'b000,0,0,4'b0000,3'b000,0,2'b00,0,0,3'b000,2'b00,1,1,0), "illegal_00011");

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
